// File: rtl/fetch_pc.sv
// Fetch-stage program counter: next-PC selection, F/D PC pipeline register,
// delay-slot tracking and a one-cycle redirect bubble after exceptions/eret.
module fetch_pc (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        cmp,
  input  logic        branch,
  input  logic        jump_imm,
  input  logic        jump_reg,
  input  logic [15:0] imm16,
  input  logic [25:0] index26,
  input  logic [31:0] rs_data,
  input  logic        exc_req,
  input  logic        eret,
  input  logic [31:0] epc,
  output logic [31:0] pc_f,
  output logic [31:0] pc_d,
  output logic [31:0] pc8_d,
  output logic        bd_f,
  output logic        adel_f,
  output logic        flush_f
);

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_PC   = 32'h0000_4180;
  localparam logic [31:0] TEXT_LO  = 32'h0000_3000;
  localparam logic [31:0] TEXT_HI  = 32'h0000_4FFC;

  typedef enum logic {
    RUN   = 1'b0,
    REDIR = 1'b1
  } state_t;

  state_t      state, state_next;
  logic [31:0] pc_f_next, pc_d_next;
  logic        bd_next;
  logic [31:0] pc_d_plus4, seq_pc, btarget, jtarget;
  logic        redirect;

  assign pc_d_plus4 = pc_d + 32'd4;
  assign seq_pc     = pc_f + 32'd4;
  assign btarget    = pc_d_plus4 + {{14{imm16[15]}}, imm16, 2'b00};
  assign jtarget    = {pc_d_plus4[31:28], index26, 2'b00};
  assign redirect   = exc_req | eret;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      pc_f  <= RESET_PC;
      pc_d  <= 32'h0;
      bd_f  <= 1'b0;
    end else begin
      state <= state_next;
      pc_f  <= pc_f_next;
      pc_d  <= pc_d_next;
      bd_f  <= bd_next;
    end
  end

  // Redirects beat stall; in REDIR the fetched word is a bubble, so control
  // inputs from D are ignored and the bubble never counts as a delay slot.
  always_comb begin
    state_next = RUN;
    pc_f_next  = pc_f;
    pc_d_next  = pc_d;
    bd_next    = bd_f;
    if (redirect) begin
      state_next = REDIR;
      pc_f_next  = exc_req ? EXC_PC : epc;
      bd_next    = 1'b0;
    end else if (stall) begin
      state_next = RUN;
    end else if (state == REDIR) begin
      pc_f_next = seq_pc;
      pc_d_next = pc_f;
      bd_next   = 1'b0;
    end else begin
      pc_d_next = pc_f;
      bd_next   = branch | jump_imm | jump_reg;
      if (jump_reg)             pc_f_next = rs_data;
      else if (jump_imm)        pc_f_next = jtarget;
      else if (branch && cmp)   pc_f_next = btarget;
      else                      pc_f_next = seq_pc;
    end
  end

  assign flush_f = (state == REDIR);
  assign pc8_d   = pc_d + 32'd8;
  assign adel_f  = (state == RUN) &&
                   ((pc_f[1:0] != 2'b00) || (pc_f < TEXT_LO) || (pc_f > TEXT_HI));

endmodule

// File: tb/tb_fetch_pc.sv
// Self-checking bench for fetch_pc: reference model feeds an expected queue
// each cycle; directed scenarios add fixed-value checks on top.
module tb_fetch_pc;

  localparam int W = 99;

  logic        clk = 1'b0;
  logic        reset, stall, cmp, branch, jump_imm, jump_reg, exc_req, eret;
  logic [15:0] imm16;
  logic [25:0] index26;
  logic [31:0] rs_data, epc;
  logic [31:0] pc_f, pc_d, pc8_d;
  logic        bd_f, adel_f, flush_f;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_v;
  int checks = 0;
  int errors = 0;

  logic [31:0] m_pc_f, m_pc_d;
  logic        m_bd, m_redir;

  fetch_pc dut (
    .clk(clk), .reset(reset), .stall(stall), .cmp(cmp), .branch(branch),
    .jump_imm(jump_imm), .jump_reg(jump_reg), .imm16(imm16), .index26(index26),
    .rs_data(rs_data), .exc_req(exc_req), .eret(eret), .epc(epc),
    .pc_f(pc_f), .pc_d(pc_d), .pc8_d(pc8_d), .bd_f(bd_f), .adel_f(adel_f),
    .flush_f(flush_f)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] observed();
    return {pc_f, pc_d, pc8_d, bd_f, flush_f, adel_f};
  endfunction

  task automatic idle_inputs();
    reset = 0; stall = 0; cmp = 0; branch = 0; jump_imm = 0; jump_reg = 0;
    exc_req = 0; eret = 0; imm16 = '0; index26 = '0; rs_data = '0; epc = '0;
  endtask

  // Advance the model with the current inputs, queue the expected outputs,
  // then let the DUT take the same clock edge.
  task automatic cycle();
    logic [31:0] pd4, bt, jt;
    logic        adel;
    pd4 = m_pc_d + 32'd4;
    bt  = pd4 + {{14{imm16[15]}}, imm16, 2'b00};
    jt  = {pd4[31:28], index26, 2'b00};
    if (reset) begin
      m_pc_f = 32'h3000; m_pc_d = 32'h0; m_bd = 0; m_redir = 0;
    end else if (exc_req || eret) begin
      m_pc_f = exc_req ? 32'h4180 : epc; m_bd = 0; m_redir = 1;
    end else if (stall) begin
      m_redir = 0;
    end else if (m_redir) begin
      m_pc_d = m_pc_f; m_pc_f = m_pc_f + 32'd4; m_bd = 0; m_redir = 0;
    end else begin
      m_pc_d = m_pc_f;
      m_bd   = branch | jump_imm | jump_reg;
      if (jump_reg)           m_pc_f = rs_data;
      else if (jump_imm)      m_pc_f = jt;
      else if (branch && cmp) m_pc_f = bt;
      else                    m_pc_f = m_pc_f + 32'd4;
    end
    adel = !m_redir && ((m_pc_f[1:0] != 2'b00) || (m_pc_f < 32'h3000) ||
                        (m_pc_f > 32'h4FFC));
    exp_q.push_back({m_pc_f, m_pc_d, m_pc_d + 32'd8, m_bd, m_redir, adel});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs(); reset = 1; cycle(); idle_inputs();
    exp_v = exp_q.pop_front(); checks++;
    if (observed() !== exp_v) begin
      errors++; $display("FAIL sb_reset: got %h expected %h", observed(), exp_v);
    end
    checks++;
    if (pc_f !== 32'h3000 || pc_d !== 32'h0 || pc8_d !== 32'h8 || bd_f !== 1'b0 ||
        adel_f !== 1'b0 || flush_f !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: pc_f=%h pc_d=%h pc8_d=%h bd=%b adel=%b flush=%b expected 3000/0/8/0/0/0",
               pc_f, pc_d, pc8_d, bd_f, adel_f, flush_f);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] want [3] = '{32'h3004, 32'h3008, 32'h300C};
    for (int i = 0; i < 3; i++) begin
      cycle();
      exp_v = exp_q.pop_front(); checks++;
      if (observed() !== exp_v) begin
        errors++; $display("FAIL sb_seq: got %h expected %h", observed(), exp_v);
      end
      checks++;
      if (pc_f !== want[i] || bd_f !== 1'b0) begin
        errors++; $display("FAIL seq_pc: pc_f=%h bd=%b expected %h bd=0", pc_f, bd_f, want[i]);
      end
    end
  endtask

  task automatic test_branch();
    idle_inputs(); reset = 1; cycle(); idle_inputs();
    cycle(); cycle();
    void'(exp_q.pop_front()); void'(exp_q.pop_front()); void'(exp_q.pop_front());
    branch = 1; cmp = 1; imm16 = 16'hFFFF; cycle();
    exp_v = exp_q.pop_front(); checks++;
    if (observed() !== exp_v) begin
      errors++; $display("FAIL sb_branch_taken: got %h expected %h", observed(), exp_v);
    end
    checks++;
    if (pc_f !== 32'h3004 || bd_f !== 1'b1 || pc_d !== 32'h3008) begin
      errors++; $display("FAIL branch_taken: pc_f=%h bd=%b pc_d=%h expected 3004/1/3008", pc_f, bd_f, pc_d);
    end
    cmp = 0; cycle(); idle_inputs();
    exp_v = exp_q.pop_front(); checks++;
    if (observed() !== exp_v) begin
      errors++; $display("FAIL sb_branch_not_taken: got %h expected %h", observed(), exp_v);
    end
    checks++;
    if (pc_f !== 32'h3008 || bd_f !== 1'b1) begin
      errors++; $display("FAIL branch_not_taken: pc_f=%h bd=%b expected 3008/1", pc_f, bd_f);
    end
    index26 = 26'h0000C10; jump_imm = 1; cycle(); idle_inputs();
    exp_v = exp_q.pop_front(); checks++;
    if (pc_f !== 32'h3040 || observed() !== exp_v) begin
      errors++; $display("FAIL jump_imm: got %h expected %h (pc_f 3040)", observed(), exp_v);
    end
  endtask

  task automatic test_stall();
    idle_inputs(); reset = 1; cycle(); idle_inputs();
    for (int i = 0; i < 4; i++) cycle();
    for (int i = 0; i < 5; i++) void'(exp_q.pop_front());
    stall = 1;
    for (int i = 0; i < 2; i++) begin
      cycle();
      exp_v = exp_q.pop_front(); checks++;
      if (observed() !== exp_v || pc_f !== 32'h3010 || pc_d !== 32'h300C) begin
        errors++; $display("FAIL stall_hold: got %h expected %h (pc_f 3010 pc_d 300c)", observed(), exp_v);
      end
    end
    stall = 0; cycle();
    exp_v = exp_q.pop_front(); checks++;
    if (observed() !== exp_v || pc_f !== 32'h3014) begin
      errors++; $display("FAIL stall_release: got %h expected %h (pc_f 3014)", observed(), exp_v);
    end
  endtask

  task automatic test_exc_over_stall();
    stall = 1; exc_req = 1; cycle(); idle_inputs();
    exp_v = exp_q.pop_front(); checks++;
    if (observed() !== exp_v || pc_f !== 32'h4180 || flush_f !== 1'b1 || bd_f !== 1'b0 || adel_f !== 1'b0) begin
      errors++; $display("FAIL exc_stall: got %h expected %h (pc_f 4180 flush 1)", observed(), exp_v);
    end
    branch = 1; cmp = 1; jump_reg = 1; rs_data = 32'h3100; cycle(); idle_inputs();
    exp_v = exp_q.pop_front(); checks++;
    if (observed() !== exp_v || pc_f !== 32'h4184 || flush_f !== 1'b0 || bd_f !== 1'b0) begin
      errors++; $display("FAIL redir_exit: got %h expected %h (pc_f 4184 flush 0)", observed(), exp_v);
    end
  endtask

  task automatic test_jr_eret();
    jump_reg = 1; rs_data = 32'h3002; cycle(); idle_inputs();
    exp_v = exp_q.pop_front(); checks++;
    if (observed() !== exp_v || pc_f !== 32'h3002 || adel_f !== 1'b1) begin
      errors++; $display("FAIL jr_misaligned: got %h expected %h (pc_f 3002 adel 1)", observed(), exp_v);
    end
    eret = 1; epc = 32'h3020; cycle(); idle_inputs();
    exp_v = exp_q.pop_front(); checks++;
    if (observed() !== exp_v || pc_f !== 32'h3020 || flush_f !== 1'b1) begin
      errors++; $display("FAIL eret: got %h expected %h (pc_f 3020 flush 1)", observed(), exp_v);
    end
    cycle();
    exp_v = exp_q.pop_front(); checks++;
    if (observed() !== exp_v || flush_f !== 1'b0) begin
      errors++; $display("FAIL eret_exit: got %h expected %h (flush 0)", observed(), exp_v);
    end
  endtask

  task automatic test_back_to_back();
    exc_req = 1; cycle();
    exc_req = 0; eret = 1; epc = 32'h3200; cycle(); idle_inputs();
    void'(exp_q.pop_front());
    exp_v = exp_q.pop_front(); checks++;
    if (observed() !== exp_v || pc_f !== 32'h3200 || flush_f !== 1'b1) begin
      errors++; $display("FAIL redirect_in_redir: got %h expected %h (pc_f 3200 flush 1)", observed(), exp_v);
    end
    exc_req = 1; cycle(); idle_inputs(); reset = 1; cycle(); idle_inputs();
    void'(exp_q.pop_front());
    exp_v = exp_q.pop_front(); checks++;
    if (observed() !== exp_v || pc_f !== 32'h3000 || flush_f !== 1'b0 || pc8_d !== 32'h8) begin
      errors++; $display("FAIL reset_mid_redir: got %h expected %h (pc_f 3000 flush 0)", observed(), exp_v);
    end
  endtask

  task automatic test_wrap();
    jump_reg = 1; rs_data = 32'hFFFF_FFFC; cycle(); idle_inputs(); cycle();
    void'(exp_q.pop_front());
    exp_v = exp_q.pop_front(); checks++;
    if (observed() !== exp_v || pc_f !== 32'h0 || adel_f !== 1'b1) begin
      errors++; $display("FAIL wrap: got %h expected %h (pc_f 0 adel 1)", observed(), exp_v);
    end
    jump_reg = 1; rs_data = 32'h4FFC; cycle(); idle_inputs();
    exp_v = exp_q.pop_front(); checks++;
    if (observed() !== exp_v || adel_f !== 1'b0) begin
      errors++; $display("FAIL top_of_text: got %h expected %h (adel 0)", observed(), exp_v);
    end
    cycle();
    exp_v = exp_q.pop_front(); checks++;
    if (observed() !== exp_v || pc_f !== 32'h5000 || adel_f !== 1'b1) begin
      errors++; $display("FAIL past_text: got %h expected %h (pc_f 5000 adel 1)", observed(), exp_v);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset    = ($urandom_range(0, 49) == 0);
      exc_req  = ($urandom_range(0, 15) == 0);
      eret     = ($urandom_range(0, 15) == 0);
      stall    = ($urandom_range(0, 4) == 0);
      branch   = ($urandom_range(0, 3) == 0);
      cmp      = $urandom_range(0, 1);
      jump_imm = ($urandom_range(0, 7) == 0);
      jump_reg = ($urandom_range(0, 7) == 0);
      imm16    = 16'($urandom);
      index26  = 26'($urandom);
      rs_data  = ($urandom_range(0, 3) == 0) ? $urandom : {18'h0, 2'($urandom_range(0, 3)) + 2'd3, 10'($urandom) & 10'h3FC, 2'b00};
      epc      = {16'h0, 4'h3 + 4'($urandom_range(0, 1)), 12'($urandom)};
      cycle();
      exp_v = exp_q.pop_front(); checks++;
      if (observed() !== exp_v) begin
        errors++; $display("FAIL sb_random[%0d]: got %h expected %h", i, observed(), exp_v);
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    @(posedge clk); #1;
    test_reset();
    test_sequential();
    test_branch();
    test_stall();
    test_exc_over_stall();
    test_jr_eret();
    test_back_to_back();
    test_wrap();
    test_random();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL sb_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
